// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and op decode helpers for the multiply/divide engine
package muldiv_pkg;

  typedef enum logic [1:0] {
    MULTU = 2'b00,
    MULT  = 2'b01,
    DIVU  = 2'b10,
    DIV   = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  function automatic logic is_div(op_t op);
    return op[1];
  endfunction

  function automatic logic is_signed(op_t op);
    return op[0];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - request/result bundle between the control unit and the muldiv engine
interface muldiv_if #(
  parameter int WIDTH = 32
);
  import muldiv_pkg::*;

  logic             start;
  op_t              op;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic             flush;
  logic             busy;
  logic             done;
  logic             divZero;
  logic [WIDTH-1:0] oHi;
  logic [WIDTH-1:0] oLo;

  modport master (
    output start, op, iA, iB, flush,
    input  busy, done, divZero, oHi, oLo
  );

  modport slave (
    input  start, op, iA, iB, flush,
    output busy, done, divZero, oHi, oLo
  );

endinterface

// File: rtl/muldiv_negate.sv
// rtl/muldiv_negate.sv - conditional two's-complement negate of an N-bit value
module muldiv_negate #(
  parameter int N = 32
) (
  input  logic         neg,
  input  logic [N-1:0] x,
  output logic [N-1:0] y
);

  assign y = neg ? -x : x;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative shift-add multiplier / restoring divider producing HI/LO
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);

  state_t             state;
  op_t                opReg;
  logic               sA, sB, zeroDiv;
  logic [WIDTH-1:0]   aReg, bMag, accHi, accLo;
  logic [CNT_W-1:0]   cnt;
  logic               doneReg, divZeroReg;
  logic [WIDTH-1:0]   hiReg, loReg;

  logic               negA, negB;
  logic [WIDTH-1:0]   absA, absB;
  logic [WIDTH:0]     mulSum, divShift, divDiff;
  logic               divOk;
  logic [WIDTH-1:0]   nextHi, nextLo;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quoFix, remFix;

  assign negA = is_signed(bus.op) & bus.iA[WIDTH-1];
  assign negB = is_signed(bus.op) & bus.iB[WIDTH-1];

  muldiv_negate #(.N(WIDTH))   uAbsA   (.neg(negA),    .x(bus.iA),         .y(absA));
  muldiv_negate #(.N(WIDTH))   uAbsB   (.neg(negB),    .x(bus.iB),         .y(absB));
  muldiv_negate #(.N(2*WIDTH)) uFixPrd (.neg(sA ^ sB), .x({accHi, accLo}), .y(prodFix));
  muldiv_negate #(.N(WIDTH))   uFixQuo (.neg(sA ^ sB), .x(accLo),          .y(quoFix));
  muldiv_negate #(.N(WIDTH))   uFixRem (.neg(sA),      .x(accHi),          .y(remFix));

  // accHi/accLo are the product halves for multiply and remainder/quotient for divide
  always_comb begin
    mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, aReg} : '0);
    divShift = {accHi, accLo[WIDTH-1]};
    divDiff  = divShift - {1'b0, bMag};
    divOk    = !divDiff[WIDTH];
    if (is_div(opReg)) begin
      nextHi = divOk ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];
      nextLo = {accLo[WIDTH-2:0], divOk};
    end else begin
      nextHi = mulSum[WIDTH:1];
      nextLo = {mulSum[0], accLo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      opReg      <= MULTU;
      sA         <= 1'b0;
      sB         <= 1'b0;
      zeroDiv    <= 1'b0;
      aReg       <= '0;
      bMag       <= '0;
      accHi      <= '0;
      accLo      <= '0;
      cnt        <= '0;
      doneReg    <= 1'b0;
      divZeroReg <= 1'b0;
      hiReg      <= '0;
      loReg      <= '0;
    end else if (bus.flush) begin
      state   <= IDLE;
      doneReg <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            opReg      <= bus.op;
            sA         <= negA;
            sB         <= negB;
            // divide keeps the raw dividend in aReg for the divide-by-zero result
            aReg       <= is_div(bus.op) ? bus.iA : absA;
            bMag       <= absB;
            accHi      <= '0;
            accLo      <= is_div(bus.op) ? absA : absB;
            zeroDiv    <= is_div(bus.op) && (bus.iB == '0);
            cnt        <= CNT_W'(WIDTH);
            divZeroReg <= 1'b0;
            state      <= CALC;
          end
        end
        CALC: begin
          accHi <= nextHi;
          accLo <= nextLo;
          cnt   <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          if (zeroDiv) begin
            hiReg      <= aReg;
            loReg      <= '1;
            divZeroReg <= 1'b1;
          end else if (is_div(opReg)) begin
            hiReg <= remFix;
            loReg <= quoFix;
          end else begin
            hiReg <= prodFix[2*WIDTH-1:WIDTH];
            loReg <= prodFix[WIDTH-1:0];
          end
          doneReg <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = doneReg;
  assign bus.divZero = divZeroReg;
  assign bus.oHi     = hiReg;
  assign bus.oLo     = loReg;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit with directed vectors
module tb_muldiv_unit;
  import muldiv_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   doneCount = 0;
  exp_t expQ[$];

  muldiv_if #(.WIDTH(32)) bus ();
  muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.done) begin
      exp_t e;
      doneCount++;
      if (expQ.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done with hi=%h lo=%h expected no done", bus.oHi, bus.oLo);
      end else begin
        e = expQ.pop_front();
        check("result_hi", 64'(bus.oHi), 64'(e.hi));
        check("result_lo", 64'(bus.oLo), 64'(e.lo));
        check("result_divZero", 64'(bus.divZero), 64'(e.dz));
      end
    end
  end

  // Call at a negedge; returns at the negedge where done is observed.
  task automatic runOp(input op_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eHi, input logic [31:0] eLo, input logic eDz,
                       input int disturb);
    int   n;
    logic busyOk;
    exp_t e;
    bus.start = 1'b1;
    bus.op    = op;
    bus.iA    = a;
    bus.iB    = b;
    e.hi = eHi;
    e.lo = eLo;
    e.dz = eDz;
    expQ.push_back(e);
    n      = 0;
    busyOk = 1'b1;
    do begin
      @(negedge clk);
      n++;
      bus.start = (n == disturb);
      if (n == disturb) begin
        bus.op = DIVU;
        bus.iA = 32'h63;
        bus.iB = 32'h0;
      end
      if (!bus.done && !bus.busy) busyOk = 1'b0;
    end while (!bus.done && n < 100);
    check("latency", 64'(n), 64'd34);
    check("busy_during_op", 64'(busyOk), 64'd1);
    check("busy_low_at_done", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int dc;
    bus.start = 1'b0;
    bus.op    = MULTU;
    bus.iA    = '0;
    bus.iB    = '0;
    bus.flush = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_divZero", 64'(bus.divZero), 64'd0);
    check("reset_hi", 64'(bus.oHi), 64'd0);
    check("reset_lo", 64'(bus.oLo), 64'd0);
    rst = 1'b0;

    @(negedge clk);
    runOp(MULTU, 32'hFFFFFFFF, 32'h2, 32'h1, 32'hFFFFFFFE, 1'b0, 0);
    @(negedge clk);
    runOp(MULT, 32'hFFFFFFFD, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 0);
    runOp(MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0, 0);
    runOp(MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0, 0);
    @(negedge clk);
    runOp(DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0);
    runOp(DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 0);
    runOp(DIV, 32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 1'b0, 0);
    @(negedge clk);
    runOp(DIVU, 32'h7, 32'h0, 32'h7, 32'hFFFFFFFF, 1'b1, 0);
    runOp(DIVU, 32'h9, 32'h4, 32'h1, 32'h2, 1'b0, 0);
    runOp(DIV, 32'hFFFFFFF8, 32'h0, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1, 0);
    runOp(DIVU, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF, 1'b0, 0);

    // ignored start pulse and operand change mid-op
    @(negedge clk);
    runOp(MULTU, 32'h3, 32'h4, 32'h0, 32'hC, 1'b0, 5);

    // flush at cycle 10 of an op
    @(negedge clk);
    dc = doneCount;
    bus.start = 1'b1;
    bus.op    = MULTU;
    bus.iA    = 32'h7;
    bus.iB    = 32'h7;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", 64'(bus.busy), 64'd0);
    repeat (40) @(negedge clk);
    check("flush_no_done", 64'(doneCount), 64'(dc));
    check("flush_hold_hi", 64'(bus.oHi), 64'd0);
    check("flush_hold_lo", 64'(bus.oLo), 64'hC);

    // reset at cycle 20 of a DIV, after a divide-by-zero set the flag
    @(negedge clk);
    runOp(DIVU, 32'h5, 32'h0, 32'h5, 32'hFFFFFFFF, 1'b1, 0);
    @(negedge clk);
    dc = doneCount;
    bus.start = 1'b1;
    bus.op    = DIV;
    bus.iA    = 32'd100;
    bus.iB    = 32'd7;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_divZero", 64'(bus.divZero), 64'd0);
    check("rst_hi", 64'(bus.oHi), 64'd0);
    check("rst_lo", 64'(bus.oLo), 64'd0);
    repeat (40) @(negedge clk);
    check("rst_no_done", 64'(doneCount), 64'(dc));
    runOp(MULT, 32'h6, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0, 0);

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(expQ.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle multiply/divide unit that produces HI/LO results for the MIPS54 multi-cycle core. It supersedes the combinational multiplier and fixed-width divider in the datapath with a single iterative engine. The engine has a start/busy/done handshake, a flush for exception entry, and explicit divide-by-zero reporting. The control unit stalls on `busy` and loads HI/LO from `oHi`/`oLo` when `done` is asserted.

## Interface
- `WIDTH`, 32: operand width; also the iteration count. Must be ≥ 4.
- `CNT_W`, `$clog2(WIDTH+1)`: iteration counter width (derived; do not override).

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: request; sampled only in IDLE.
- `op` in 2: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `iA` in WIDTH: multiplicand / dividend.
- `iB` in WIDTH: multiplier / divisor.
- `flush` in 1: abort the current operation (exception or eret).
- `busy` out 1: operation in flight.
- `done` out 1: one-cycle pulse; results valid.
- `divZero` out 1: last completed op was a divide with `iB == 0`.
- `oHi` out WIDTH: product high half / remainder.
- `oLo` out WIDTH: product low half / quotient.

## Operation
- States are IDLE, CALC and FIX.
- **IDLE → CALC:** on `start & !flush`.
  - Latch `op`.
  - Latch `|iA|` and `|iB|` (magnitude for signed ops, raw value for unsigned ops).
  - Latch sign bits.
  - Load counter = WIDTH.
  - Clear `divZero`.
- **CALC:**
  - Multiply: shift-add, 1 bit per cycle, over a 2·WIDTH accumulator.
  - Divide: restoring division, 1 quotient bit per cycle.
  - Counter decrements each cycle; at 1 go to FIX.
- **FIX:**
  - Apply sign correction:
    - Product negated if sA^sB.
    - Quotient negated if sA^sB.
    - Remainder takes sign of sA.
  - Register `oHi`/`oLo`.
  - Pulse `done`, go to IDLE.
- **Divide by zero** (DIV/DIVU with `iB == 0`):
  - Same latency, no sign fix.
  - `oHi` = original `iA`, `oLo` = all ones, `divZero` = 1.
- **Signed overflow:** DIV of min-int by −1 gives `oLo` = min-int, `oHi` = 0, no flag.
- Operands are latched at start, so `iA`/`iB`/`op` may change while `busy` is high.
- `start` while `busy` is ignored (no queueing).
- **`flush`:**
  - Priority over `start`.
  - Any state → IDLE next edge.
  - No `done` pulse.
  - `oHi`/`oLo`/`divZero` keep their previous values.
- `oHi`/`oLo` hold until the next FIX.

## Timing
- Reset values:
  - state = IDLE
  - `busy` = 0, `done` = 0, `divZero` = 0
  - `oHi` = 0, `oLo` = 0
  - counter and accumulators = 0
- `rst` mid-operation: same as reset, and no `done`.
- `busy` is combinational from state (`state != IDLE`). It rises in the cycle after the accepting edge.
- Cycle numbering: start accepted at edge E.
  - CALC occupies edges E+1 … E+WIDTH.
  - FIX at edge E+WIDTH+1 writes results.
  - `done` = 1 and `busy` = 0 in the cycle after E+WIDTH+1.
  - Latency is WIDTH+2 edges; 34 for WIDTH = 32.
- `done` is registered, high exactly one cycle.
- `start` asserted during the `done` cycle is accepted, giving back-to-back throughput of one op per WIDTH+2 cycles.
- `flush` and FIX on the same edge: flush wins, no result write.

## Structure
- Package `muldiv_pkg`:
  - `op_t` enum: MULTU = 2'b00, MULT = 2'b01, DIVU = 2'b10, DIV = 2'b11.
  - `state_t` enum: IDLE, CALC, FIX.
  - Helper `is_div(op)` = `op[1]`; `is_signed(op)` = `op[0]`.
- One natural sub-module, `muldiv_negate`: a parametrised conditional two's-complement (`neg ? -x : x`) of width N. It is instanced for operand abs, product fix and quotient/remainder fix.
- Everything else lives in a single module with the FSM and datapath.

## Test plan
All timing below is with WIDTH = 32.

1. MULTU `iA` = 0xFFFFFFFF, `iB` = 2 → `oHi` = 0x00000001, `oLo` = 0xFFFFFFFE. `done` 34 edges after start; `busy` high throughout.
2. MULT −3 × 5 → `oHi` = 0xFFFFFFFF, `oLo` = 0xFFFFFFF1. Back-to-back start in the `done` cycle with MULT 0x80000000 × 0x80000000 → `oHi` = 0x40000000, `oLo` = 0.
3. DIV −7 / 2 → `oLo` = 0xFFFFFFFD, `oHi` = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → `oLo` = 0x80000000, `oHi` = 0, `divZero` = 0.
4. DIVU 7 / 0 → `divZero` = 1, `oHi` = 7, `oLo` = 0xFFFFFFFF, normal latency. The following DIVU 9/4 clears `divZero` and gives `oLo` = 2, `oHi` = 1.
5. Start MULTU, then `flush` at cycle 10 → `busy` low next cycle, no `done`, results keep the prior values. A `start` pulse at cycle 5 of an op is ignored, and changing `iA` mid-op does not affect the result.
6. Assert `rst` at cycle 20 of a DIV → all outputs 0 next cycle, no `done`. A new op after reset completes correctly.
